// File: rtl/seq_pkg.sv
// Shared types and parameter-checking helpers for the sequential counter blocks.
package seq_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  // A modulus is legal when it is at least 2 and fits in the register width.
  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (modulus >= 2) && ($clog2(modulus) <= width);
  endfunction

  function automatic bit reset_val_ok(input int modulus, input int reset_val);
    return (reset_val >= 0) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_tff_cell.sv
// Single toggle flip-flop with asynchronous reset to a per-bit reset value.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous load, count enable, terminal count
// and a one-cycle wrap pulse. The count register is built from toggle cells.
module mod_n_updown_counter
  import seq_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrapped
);

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (!reset_val_ok(MODULUS, RESET_VAL)) begin : g_bad_reset_val
    $error("mod_n_updown_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  count_dir_e       dir;
  logic             at_max;
  logic             at_min;
  logic             load_in_range;
  logic [WIDTH-1:0] next_q;
  logic             next_wrapped;
  logic [WIDTH-1:0] t;

  assign dir           = count_dir_e'(up);
  assign at_max        = (Q == MAX_Q);
  assign at_min        = (Q == '0);
  assign load_in_range = ({1'b0, load_val} < MOD_EXT);

  assign tc = en & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_min));

  // Wrap at MODULUS explicitly so non-power-of-two ranges never leak past MAX_Q.
  always_comb begin
    next_q       = Q;
    next_wrapped = 1'b0;
    if (load) begin
      next_q = load_in_range ? load_val : MAX_Q;
    end else if (en) begin
      if (dir == DIR_UP) begin
        next_q       = at_max ? '0 : Q + WIDTH'(1);
        next_wrapped = at_max;
      end else begin
        next_q       = at_min ? MAX_Q : Q - WIDTH'(1);
        next_wrapped = at_min;
      end
    end
  end

  // Each cell toggles exactly when its bit must change to reach next_q.
  assign t = Q ^ next_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .t       (t[i]),
      .rst_val (RST_Q[i]),
      .q       (Q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= next_wrapped;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench: mod-8 up count, mod-10 table of vectors, async reset cases
// and a two-stage cascade.
module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // mod-8 instance
  logic       rst8, en8, up8, load8;
  logic [2:0] lv8, q8;
  logic       tc8, w8;

  // mod-10 instance
  logic       rst10, en10, up10, load10;
  logic [3:0] lv10, q10;
  logic       tc10, w10;

  // cascaded pair of mod-8 stages
  logic       rstc, enc;
  logic [2:0] lvc, qlo, qhi;
  logic       tclo, tchi, wlo, whi;

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .load_val(lv8),
    .Q(q8), .tc(tc8), .wrapped(w8)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut10 (
    .clk(clk), .rst(rst10), .en(en10), .up(up10), .load(load10), .load_val(lv10),
    .Q(q10), .tc(tc10), .wrapped(w10)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_lo (
    .clk(clk), .rst(rstc), .en(enc), .up(1'b1), .load(1'b0), .load_val(lvc),
    .Q(qlo), .tc(tclo), .wrapped(wlo)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_hi (
    .clk(clk), .rst(rstc), .en(tclo), .up(1'b1), .load(1'b0), .load_val(lvc),
    .Q(qhi), .tc(tchi), .wrapped(whi)
  );

  typedef struct packed {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       exp_tc;   // before the edge, with these inputs applied
    logic [3:0] exp_q;    // after the edge
    logic       exp_w;    // after the edge
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic e, input logic u, input logic l,
                              input logic [3:0] lv, input logic etc,
                              input logic [3:0] eq, input logic ew);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.load_val = lv;
    v.exp_tc = etc; v.exp_q = eq; v.exp_w = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst8 = 1'b1; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; lv8 = '0;
    rst10 = 1'b1; en10 = 1'b0; up10 = 1'b0; load10 = 1'b0; lv10 = '0;
    rstc = 1'b1; enc = 1'b0; lvc = '0;

    vecs[0]  = mk(1, 0, 0, 4'd0,  1, 4'd9, 1);
    vecs[1]  = mk(1, 0, 0, 4'd0,  0, 4'd8, 0);
    vecs[2]  = mk(1, 0, 0, 4'd0,  0, 4'd7, 0);
    vecs[3]  = mk(0, 0, 1, 4'd12, 0, 4'd9, 0);
    vecs[4]  = mk(1, 1, 1, 4'd4,  1, 4'd4, 0);
    vecs[5]  = mk(1, 1, 0, 4'd0,  0, 4'd5, 0);
    vecs[6]  = mk(1, 1, 0, 4'd0,  0, 4'd6, 0);
    vecs[7]  = mk(1, 0, 0, 4'd0,  0, 4'd5, 0);
    vecs[8]  = mk(1, 0, 0, 4'd0,  0, 4'd4, 0);
    vecs[9]  = mk(1, 0, 0, 4'd0,  0, 4'd3, 0);
    vecs[10] = mk(0, 0, 0, 4'd0,  0, 4'd3, 0);
    vecs[11] = mk(0, 1, 0, 4'd0,  0, 4'd3, 0);
    vecs[12] = mk(0, 0, 1, 4'd8,  0, 4'd8, 0);
    vecs[13] = mk(1, 1, 0, 4'd0,  0, 4'd9, 0);
    vecs[14] = mk(1, 1, 0, 4'd0,  1, 4'd0, 1);
    vecs[15] = mk(0, 1, 0, 4'd0,  0, 4'd0, 0);
    vecs[16] = mk(1, 0, 0, 4'd0,  1, 4'd9, 1);
    vecs[17] = mk(0, 1, 0, 4'd0,  0, 4'd9, 0);
    vecs[18] = mk(0, 0, 1, 4'd15, 0, 4'd9, 0);
    vecs[19] = mk(0, 0, 1, 4'd0,  0, 4'd0, 0);
    vecs[20] = mk(1, 0, 1, 4'd10, 1, 4'd9, 0);
    vecs[21] = mk(0, 0, 1, 4'd9,  0, 4'd9, 0);
    vecs[22] = mk(1, 1, 0, 4'd0,  1, 4'd0, 1);

    // reset state, before any clock edge
    #2;
    check("rst_q10", 8'(q10), 8'd0);
    check("rst_w10", 8'(w10), 8'd0);
    check("rst_q8", 8'(q8), 8'd0);
    check("rst_qcasc", 8'({qhi, qlo}), 8'd0);

    @(negedge clk);
    rst8 = 1'b0; rst10 = 1'b0; rstc = 1'b0;

    // mod-10 vector table
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      en10 = vecs[i].en; up10 = vecs[i].up; load10 = vecs[i].load; lv10 = vecs[i].load_val;
      #1;
      check($sformatf("vec%0d_tc", i), 8'(tc10), 8'(vecs[i].exp_tc));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), 8'(q10), 8'(vecs[i].exp_q));
      check($sformatf("vec%0d_w", i), 8'(w10), 8'(vecs[i].exp_w));
    end

    // async reset mid-cycle at Q=6 while counting up
    @(negedge clk);
    en10 = 1'b0; load10 = 1'b1; lv10 = 4'd6;
    @(posedge clk); #1;
    check("pre_rst_q6", 8'(q10), 8'd6);
    @(negedge clk);
    load10 = 1'b0; en10 = 1'b1; up10 = 1'b1;
    #2 rst10 = 1'b1;
    #1;
    check("async_rst_q", 8'(q10), 8'd0);
    check("async_rst_w", 8'(w10), 8'd0);
    @(posedge clk); #1;
    check("rst_held_q", 8'(q10), 8'd0);
    @(negedge clk);
    rst10 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_count", 8'(q10), 8'd1);

    // async reset clears a pending wrap pulse
    @(negedge clk);
    en10 = 1'b0; load10 = 1'b1; lv10 = 4'd0;
    @(posedge clk);
    @(negedge clk);
    load10 = 1'b0; en10 = 1'b1; up10 = 1'b0;
    @(posedge clk); #1;
    check("down_wrap_q", 8'(q10), 8'd9);
    check("down_wrap_w", 8'(w10), 8'd1);
    #2 rst10 = 1'b1;
    #1;
    check("rst_clears_w", 8'(w10), 8'd0);
    check("rst_clears_q", 8'(q10), 8'd0);
    @(negedge clk);
    rst10 = 1'b0; en10 = 1'b0;

    // mod-8 free-running up count after a reset pulse
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en8 = 1'b1; up8 = 1'b1;
      #1;
      check($sformatf("m8_tc%0d", i), 8'(tc8), 8'((i % 8) == 7));
      @(posedge clk); #1;
      check($sformatf("m8_q%0d", i), 8'(q8), 8'((i + 1) % 8));
      check($sformatf("m8_w%0d", i), 8'(w8), 8'(i == 7));
    end
    @(negedge clk);
    en8 = 1'b0;

    // cascade: 70 up-counts of a 6-bit counter built from two stages
    @(negedge clk);
    enc = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      check($sformatf("casc%0d", i), 8'({qhi, qlo}), 8'((i + 1) % 64));
    end
    @(negedge clk);
    enc = 1'b0;
    check("casc_final", 8'({qhi, qlo}), 8'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
